seg_scan_display: RTL

//  Parametrised, time-multiplexed 7-segment driver for the alarm clock display.

---
 rtl/seg_scan_display.sv | 107 ++++++++++
 1 files changed

// File: rtl/seg_scan_display.sv
// Time-multiplexed 7-segment driver: scans NUM_DIGITS BCD digits from a per-frame
// snapshot of the clock/alarm source, with leading-zero blanking and per-digit blink.
module seg_scan_display #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 1000,
    parameter int unsigned BLINK_DIV  = 500000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   c_digits,
    input  logic [4*NUM_DIGITS-1:0]   a_digits,
    input  logic                      alarm,
    input  logic                      blank_lz,
    input  logic                      blink_en,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    output logic [6:0]                seg,
    output logic [NUM_DIGITS-1:0]     an
);

    localparam int unsigned SCW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)   : 1;
    localparam int unsigned BCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV)  : 1;
    localparam int unsigned IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [SCW-1:0] SCAN_LAST  = SCW'(SCAN_DIV - 1);
    localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_DIV - 1);
    localparam logic [IW-1:0]  IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [SCW-1:0]          scan_cnt_q,  scan_cnt_d;
    logic [IW-1:0]           idx_q,       idx_d;
    logic [BCW-1:0]          blink_cnt_q, blink_cnt_d;
    logic                    blink_ph_q,  blink_ph_d;
    logic [4*NUM_DIGITS-1:0] snap_q,      snap_d;
    logic [6:0]              seg_q,       seg_d;
    logic [NUM_DIGITS-1:0]   an_q,        an_d;
    logic [3:0]              digit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q  <= '0;
            idx_q       <= '0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            snap_q      <= '0;
            seg_q       <= '1;
            an_q        <= '1;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            snap_q      <= snap_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    always_comb begin
        scan_cnt_d  = scan_cnt_q + 1'b1;
        idx_d       = idx_q;
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_ph_d  = blink_ph_q;
        snap_d      = snap_q;

        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_ph_d  = ~blink_ph_q;
        end

        // Frame start: latch the source once so a frame is never torn.
        if (scan_cnt_q == '0 && idx_q == '0)
            snap_d = alarm ? a_digits : c_digits;
    end

    always_comb begin
        digit = snap_q[4*idx_q +: 4];
        case (digit)
            4'd0:    seg_d = 7'b0000001;
            4'd1:    seg_d = 7'b1001111;
            4'd2:    seg_d = 7'b0010010;
            4'd3:    seg_d = 7'b0000110;
            4'd4:    seg_d = 7'b1001100;
            4'd5:    seg_d = 7'b0100100;
            4'd6:    seg_d = 7'b0100000;
            4'd7:    seg_d = 7'b0001111;
            4'd8:    seg_d = 7'b0000000;
            4'd9:    seg_d = 7'b0000100;
            default: seg_d = 7'h7F;
        endcase

        if (blank_lz && idx_q == IDX_LAST && digit == 4'd0)
            seg_d = 7'h7F;
        if (blink_en && blink_mask[idx_q] && blink_ph_q)
            seg_d = 7'h7F;

        an_d        = '1;
        an_d[idx_q] = 1'b0;
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule
